// File: rtl/cnn_loader_pkg.sv
// Shared register map, CTRL/STATUS bit positions and TX channel state
// encoding for the CNN serial stream loader.
package cnn_loader_pkg;
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_WT     = 3'd2;
  localparam logic [2:0] REG_LN     = 3'd3;
  localparam logic [2:0] REG_RES    = 3'd4;
  localparam logic [2:0] REG_CLR    = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_WT_EN  = 1;
  localparam int CTRL_LN_EN  = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_GAP    = 4;
  localparam int CTRL_FLUSH  = 8;

  localparam int ST_WT_CNT  = 0;
  localparam int ST_LN_CNT  = 8;
  localparam int ST_RES_CNT = 16;
  localparam int ST_DONE    = 24;
  localparam int ST_WT_OVF  = 25;
  localparam int ST_LN_OVF  = 26;
  localparam int ST_RES_OVF = 27;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_e;
endpackage

// File: rtl/cnn_stream_loader_if.sv
// Wishbone classic slave bus between the management SoC and the loader.
interface cnn_stream_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/cnn_byte_fifo.sv
// Byte FIFO with wrapping pointers; a push on a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module cnn_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_full, w_pop_ok, w_push_ok;

  assign o_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~w_full | w_pop_ok);
  assign o_drop    = i_push & ~w_push_ok & ~i_flush;
  assign o_data    = r_mem[r_rd];
  assign o_count   = r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/cnn_stream_loader.sv
// Wishbone-fed transmit end of the accelerator serial byte interface:
// weight/line byte streams with programmable gap, result capture, status, irq.
module cnn_stream_loader
  import cnn_loader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  cnn_stream_loader_if.slave  wb,
  output logic                start,
  output logic [7:0]          serial_weight_data,
  output logic                serial_weight_valid,
  output logic [7:0]          serial_line_data,
  output logic                serial_line_valid,
  input  logic [7:0]          serial_result,
  input  logic                serial_result_valid,
  input  logic                done,
  output logic                irq
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int NCH = 2;  // channel 0 = weight, 1 = line

  logic               r_ack, r_start, r_irq_en, r_done_q, r_done_sticky, r_res_ovf;
  logic [31:0]        r_rdat;
  logic [NCH-1:0]     r_en, r_tx_ovf;
  logic [GAP_W-1:0]   r_gap;

  logic               w_req, w_wr, w_rd, w_flush, w_ctrl_wr;
  logic [2:0]         w_adr;
  logic [3:0]         w_clr;
  logic [NCH-1:0]     w_push, w_drop, w_valid;
  logic [NCH-1:0][7:0]    w_data;
  logic [NCH-1:0][CW-1:0] w_cnt;
  logic [7:0]         w_res_data;
  logic               w_res_empty, w_res_pop, w_res_drop;
  logic [CW-1:0]      w_res_cnt;
  logic [31:0]        w_status, w_rmux;
  logic               w_unused;

  assign w_req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~r_ack;
  assign w_wr      = w_req & wb.wbs_we_i;
  assign w_rd      = w_req & ~wb.wbs_we_i;
  assign w_adr     = wb.wbs_adr_i[4:2];
  assign w_ctrl_wr = w_wr && (w_adr == REG_CTRL);
  assign w_flush   = w_ctrl_wr & wb.wbs_dat_i[CTRL_FLUSH];
  assign w_push[0] = w_wr && (w_adr == REG_WT) && wb.wbs_sel_i[0];
  assign w_push[1] = w_wr && (w_adr == REG_LN) && wb.wbs_sel_i[0];
  assign w_res_pop = w_rd && (w_adr == REG_RES);
  assign w_clr     = (w_wr && (w_adr == REG_CLR)) ? wb.wbs_dat_i[3:0] : 4'd0;
  assign w_unused  = ^{wb.wbs_adr_i[31:5], wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:9], wb.wbs_sel_i[3:1]};

  always_comb begin
    w_status = '0;
    w_status[ST_WT_CNT  +: CW] = w_cnt[0];
    w_status[ST_LN_CNT  +: CW] = w_cnt[1];
    w_status[ST_RES_CNT +: CW] = w_res_cnt;
    w_status[ST_DONE]    = r_done_sticky;
    w_status[ST_WT_OVF]  = r_tx_ovf[0];
    w_status[ST_LN_OVF]  = r_tx_ovf[1];
    w_status[ST_RES_OVF] = r_res_ovf;
  end

  always_comb begin
    w_rmux = '0;
    case (w_adr)
      REG_CTRL: begin
        w_rmux[CTRL_WT_EN]         = r_en[0];
        w_rmux[CTRL_LN_EN]         = r_en[1];
        w_rmux[CTRL_IRQ_EN]        = r_irq_en;
        w_rmux[CTRL_GAP +: GAP_W]  = r_gap;
      end
      REG_STATUS: w_rmux = w_status;
      REG_RES:    if (!w_res_empty) w_rmux = {23'd0, 1'b1, w_res_data};
      default:    w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;  r_rdat <= '0;  r_start <= 1'b0;
      r_en <= '0;  r_irq_en <= 1'b0;  r_gap <= '0;
      r_done_q <= 1'b0;  r_done_sticky <= 1'b0;
      r_tx_ovf <= '0;  r_res_ovf <= 1'b0;
    end else begin
      r_ack    <= w_req;
      r_rdat   <= w_rd ? w_rmux : '0;
      r_start  <= 1'b0;
      r_done_q <= done;
      if (w_ctrl_wr && wb.wbs_sel_i[0]) begin
        r_start  <= wb.wbs_dat_i[CTRL_START];
        r_en     <= {wb.wbs_dat_i[CTRL_LN_EN], wb.wbs_dat_i[CTRL_WT_EN]};
        r_irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN];
        r_gap    <= wb.wbs_dat_i[CTRL_GAP +: GAP_W];
      end
      r_done_sticky <= (r_done_sticky & ~w_clr[0]) | (done & ~r_done_q);
      if (w_flush) begin
        r_tx_ovf  <= '0;
        r_res_ovf <= 1'b0;
      end else begin
        r_tx_ovf  <= (r_tx_ovf & ~w_clr[2:1]) | w_drop;
        r_res_ovf <= (r_res_ovf & ~w_clr[3]) | w_res_drop;
      end
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_tx
    tx_state_e        r_st;
    logic [GAP_W-1:0] r_cnt;
    logic             r_vld;
    logic [7:0]       r_dat;
    logic [7:0]       w_fdata;
    logic             w_empty, w_ready, w_pop;

    cnn_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .i_flush(w_flush), .i_push(w_push[ch]),
      .i_data(wb.wbs_dat_i[7:0]), .i_pop(w_pop), .o_data(w_fdata),
      .o_empty(w_empty), .o_count(w_cnt[ch]), .o_drop(w_drop[ch]));

    // The last gap cycle takes the IDLE decision itself so bytes land gap+1 apart.
    assign w_ready = r_en[ch] & ~w_empty & ~w_flush;
    assign w_pop   = w_ready & ((r_st == TX_IDLE) ||
                                (r_st == TX_SEND && r_gap == '0) ||
                                (r_st == TX_GAP && r_cnt == GAP_W'(1)));

    always_ff @(posedge clk) begin
      if (reset || w_flush) begin
        r_st  <= TX_IDLE;
        r_cnt <= '0;
        r_vld <= 1'b0;
        r_dat <= '0;
      end else begin
        r_vld <= w_pop;
        if (w_pop) r_dat <= w_fdata;
        case (r_st)
          TX_IDLE: if (w_pop) r_st <= TX_SEND;
          TX_SEND: begin
            if (|r_gap) begin
              r_st  <= TX_GAP;
              r_cnt <= r_gap;
            end else if (!w_pop) begin
              r_st <= TX_IDLE;
            end
          end
          TX_GAP: begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == GAP_W'(1)) r_st <= w_pop ? TX_SEND : TX_IDLE;
          end
          default: r_st <= TX_IDLE;
        endcase
      end
    end

    assign w_valid[ch] = r_vld;
    assign w_data[ch]  = r_dat;
  end

  cnn_byte_fifo #(.DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .reset(reset), .i_flush(w_flush), .i_push(serial_result_valid),
    .i_data(serial_result), .i_pop(w_res_pop), .o_data(w_res_data),
    .o_empty(w_res_empty), .o_count(w_res_cnt), .o_drop(w_res_drop));

  assign wb.wbs_ack_o        = r_ack;
  assign wb.wbs_dat_o        = r_rdat;
  assign start               = r_start;
  assign serial_weight_valid = w_valid[0];
  assign serial_weight_data  = w_data[0];
  assign serial_line_valid   = w_valid[1];
  assign serial_line_data    = w_data[1];
  assign irq = r_irq_en & (r_done_sticky | (|r_tx_ovf) | r_res_ovf);
endmodule
